// File: rtl/tile_mac_4x4_if.sv
// rtl/tile_mac_4x4_if.sv - tile input/output handshake bundle for tile_mac_4x4
//
// Carries both tiles with their stb/ack pair and the sweep flags, the C tile
// with its stb/ack pair, and the busy status.
// Modports: slave = the MAC engine, master = the feeder/consumer side.
interface tile_mac_4x4_if #(
    parameter int DATA_WIDTH = 32
);
    logic [16*DATA_WIDTH-1:0] A_in;
    logic [16*DATA_WIDTH-1:0] B_in;
    logic                     A_stb;
    logic                     B_stb;
    logic                     tile_first;
    logic                     tile_last;
    logic                     A_ack;
    logic                     B_ack;
    logic [16*DATA_WIDTH-1:0] C_out;
    logic                     C_stb;
    logic                     C_ack;
    logic                     busy;

    modport slave (
        input  A_in, B_in, A_stb, B_stb, tile_first, tile_last, C_ack,
        output A_ack, B_ack, C_out, C_stb, busy
    );

    modport master (
        output A_in, B_in, A_stb, B_stb, tile_first, tile_last, C_ack,
        input  A_ack, B_ack, C_out, C_stb, busy
    );
endinterface

// File: rtl/tile_mac_4x4.sv
// rtl/tile_mac_4x4.sv - row-serial 4x4 tile multiply-accumulate engine
//
// Accumulates C += A*B over the tiles of one k-sweep, one C element per cycle
// with four parallel multipliers, and presents the finished C tile for
// write-back. All arithmetic wraps modulo 2^DATA_WIDTH.
// Ports:
//   clock  - single clock, rising edge
//   reset  - synchronous, active-high
//   bus    - tile_mac_4x4_if.slave: A/B tiles + stb/ack, tile_first/tile_last,
//            C tile + stb/ack, busy
module tile_mac_4x4 #(
    parameter int DATA_WIDTH = 32
) (
    input  logic          clock,
    input  logic          reset,
    tile_mac_4x4_if.slave bus
);
    localparam int DW = DATA_WIDTH;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COMPUTE = 2'd1,
        S_OUTPUT  = 2'd2
    } state_t;

    state_t          state_q;
    state_t          state_d;
    logic [3:0]      cnt_q;
    logic            first_q;
    logic            last_q;
    logic            a_ack_q;
    logic            b_ack_q;
    logic            c_stb_q;
    logic [DW-1:0]   a_q   [16];
    logic [DW-1:0]   b_q   [16];
    logic [DW-1:0]   acc_q [16];

    logic            accept;
    logic            out_done;
    logic [1:0]      row;
    logic [1:0]      col;
    logic [DW-1:0]   dot;

    // Next-state logic; stb inputs only matter in S_IDLE, C_ack only in S_OUTPUT.
    always_comb begin
        state_d  = state_q;
        accept   = 1'b0;
        out_done = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (bus.A_stb && bus.B_stb) begin
                    accept  = 1'b1;
                    state_d = S_COMPUTE;
                end
            end
            S_COMPUTE: begin
                if (cnt_q == 4'd15) begin
                    state_d = last_q ? S_OUTPUT : S_IDLE;
                end
            end
            S_OUTPUT: begin
                if (bus.C_ack) begin
                    out_done = 1'b1;
                    state_d  = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Dot product of A row i with B column j for the element addressed by cnt.
    always_comb begin
        row = cnt_q[3:2];
        col = cnt_q[1:0];
        dot = '0;
        for (int k = 0; k < 4; k++) begin
            dot = dot + a_q[{row, k[1:0]}] * b_q[{k[1:0], col}];
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            first_q <= 1'b0;
            last_q  <= 1'b0;
            a_ack_q <= 1'b0;
            b_ack_q <= 1'b0;
            c_stb_q <= 1'b0;
            for (int n = 0; n < 16; n++) begin
                acc_q[n] <= '0;
            end
        end else begin
            state_q <= state_d;
            a_ack_q <= accept;
            b_ack_q <= accept;
            // C_stb is high exactly while the FSM sits in S_OUTPUT.
            c_stb_q <= (state_d == S_OUTPUT);

            if (accept) begin
                cnt_q   <= 4'd0;
                first_q <= bus.tile_first;
                last_q  <= bus.tile_last;
                for (int n = 0; n < 16; n++) begin
                    a_q[n] <= bus.A_in[DW*n +: DW];
                    b_q[n] <= bus.B_in[DW*n +: DW];
                end
            end

            if (state_q == S_COMPUTE) begin
                // A first tile overwrites the stale accumulator element instead of adding.
                acc_q[cnt_q] <= (first_q ? '0 : acc_q[cnt_q]) + dot;
                cnt_q        <= cnt_q + 4'd1;
            end

            if (out_done) begin
                for (int n = 0; n < 16; n++) begin
                    acc_q[n] <= '0;
                end
            end
        end
    end

    always_comb begin
        for (int n = 0; n < 16; n++) begin
            bus.C_out[DW*n +: DW] = acc_q[n];
        end
    end

    assign bus.A_ack = a_ack_q;
    assign bus.B_ack = b_ack_q;
    assign bus.C_stb = c_stb_q;
    assign bus.busy  = (state_q != S_IDLE);
endmodule

// File: tb/tb_tile_mac_4x4.sv
// tb/tb_tile_mac_4x4.sv - scoreboard bench for tile_mac_4x4
module tb_tile_mac_4x4;
    localparam int DW = 32;
    localparam int TW = 16 * DW;

    logic clock = 1'b0;
    logic reset;

    tile_mac_4x4_if #(.DATA_WIDTH(DW)) bus ();

    tile_mac_4x4 #(.DATA_WIDTH(DW)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    int            checks   = 0;
    int            failures = 0;
    logic [TW-1:0] exp_q [$];
    logic [TW-1:0] model_acc = '0;
    logic [TW-1:0] held_c    = '0;
    logic          c_stb_prev = 1'b0;

    task automatic check_tile(input string name, input logic [TW-1:0] act, input logic [TW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_val(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // ---------------- reference model (whole-tile matrix arithmetic) ----------------
    function automatic logic [DW-1:0] el(input logic [TW-1:0] t, input int i, input int j);
        return t[DW*(4*i+j) +: DW];
    endfunction

    function automatic logic [TW-1:0] tile_product(input logic [TW-1:0] a, input logic [TW-1:0] b);
        logic [TW-1:0] r;
        logic [DW-1:0] s;
        r = '0;
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                s = '0;
                for (int k = 0; k < 4; k++) begin
                    s = s + el(a, i, k) * el(b, k, j);
                end
                r[DW*(4*i+j) +: DW] = s;
            end
        end
        return r;
    endfunction

    function automatic logic [TW-1:0] tile_add(input logic [TW-1:0] x, input logic [TW-1:0] y);
        logic [TW-1:0] r;
        for (int n = 0; n < 16; n++) begin
            r[DW*n +: DW] = x[DW*n +: DW] + y[DW*n +: DW];
        end
        return r;
    endfunction

    function automatic logic [TW-1:0] fill(input logic [DW-1:0] v);
        logic [TW-1:0] r;
        for (int n = 0; n < 16; n++) r[DW*n +: DW] = v;
        return r;
    endfunction

    function automatic logic [TW-1:0] identity();
        logic [TW-1:0] r;
        r = '0;
        for (int i = 0; i < 4; i++) r[DW*(5*i) +: DW] = 1;
        return r;
    endfunction

    function automatic logic [TW-1:0] rand_tile();
        logic [TW-1:0] r;
        for (int n = 0; n < 16; n++) r[DW*n +: DW] = $urandom;
        return r;
    endfunction

    task automatic model_issue(input logic [TW-1:0] a, input logic [TW-1:0] b, input bit first, input bit last);
        if (first) model_acc = '0;
        model_acc = tile_add(model_acc, tile_product(a, b));
        if (last) begin
            exp_q.push_back(model_acc);
            model_acc = '0;
        end
    endtask

    // ---------------- monitor ----------------
    always @(negedge clock) begin
        if (reset) begin
            c_stb_prev = 1'b0;
        end else begin
            if (bus.C_stb && !c_stb_prev) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL c_unexpected: C_stb with nothing expected, C_out=%h", bus.C_out);
                end else begin
                    check_tile("c_tile", bus.C_out, exp_q.pop_front());
                end
                held_c = bus.C_out;
            end else if (bus.C_stb) begin
                check_tile("c_stable", bus.C_out, held_c);
            end
            if (bus.C_stb) check_val("ack_during_output", int'({bus.A_ack, bus.B_ack}), 0);
            c_stb_prev = bus.C_stb;
        end
    end

    // ---------------- driver helpers ----------------
    task automatic drive_tile(input logic [TW-1:0] a, input logic [TW-1:0] b, input bit first, input bit last);
        bus.A_in       = a;
        bus.B_in       = b;
        bus.tile_first = first;
        bus.tile_last  = last;
        bus.A_stb      = 1'b1;
        bus.B_stb      = 1'b1;
    endtask

    task automatic drop_stb();
        bus.A_stb = 1'b0;
        bus.B_stb = 1'b0;
    endtask

    task automatic wait_ack(output bit ok);
        int n;
        n  = 0;
        ok = 1'b0;
        while (n < 100 && !ok) begin
            @(negedge clock);
            n++;
            if (bus.A_ack) ok = 1'b1;
        end
    endtask

    // Returns at the negedge where A_ack is seen (the cycle after acceptance).
    task automatic send_tile(input logic [TW-1:0] a, input logic [TW-1:0] b,
                             input bit first, input bit last, input bit expect_out);
        bit ok;
        @(negedge clock);
        drive_tile(a, b, first, last);
        wait_ack(ok);
        check_val("ack_seen", int'(ok), 1);
        check_val("b_ack_with_a_ack", int'(bus.B_ack), 1);
        drop_stb();
        if (expect_out && ok) model_issue(a, b, first, last);
    endtask

    task automatic wait_c_stb(output int lat);
        lat = 0;
        while (!bus.C_stb && lat < 200) begin
            @(negedge clock);
            lat++;
        end
        check_val("c_stb_timeout", int'(bus.C_stb), 1);
    endtask

    task automatic wait_output(input int stall, output int lat);
        wait_c_stb(lat);
        repeat (stall) @(negedge clock);
        bus.C_ack = 1'b1;
        @(negedge clock);
        bus.C_ack = 1'b0;
        check_val("c_stb_fall", int'(bus.C_stb), 0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [TW-1:0] ta, tb_t, na, nb, bv;
        int  lat, len;
        bit  seen, ok;

        reset = 1'b1;
        bus.A_in = '0; bus.B_in = '0;
        bus.tile_first = 1'b0; bus.tile_last = 1'b0;
        bus.A_stb = 1'b0; bus.B_stb = 1'b0; bus.C_ack = 1'b0;
        repeat (3) @(negedge clock);
        check_val("rst_a_ack", int'(bus.A_ack), 0);
        check_val("rst_b_ack", int'(bus.B_ack), 0);
        check_val("rst_c_stb", int'(bus.C_stb), 0);
        check_val("rst_busy",  int'(bus.busy), 0);
        check_tile("rst_c_out", bus.C_out, '0);
        reset = 1'b0;

        // Identity x B
        for (int n = 0; n < 16; n++) bv[DW*n +: DW] = DW'(n + 1);
        send_tile(identity(), bv, 1'b1, 1'b1, 1'b1);
        @(negedge clock);
        check_val("ack_pulse_len", int'({bus.A_ack, bus.B_ack}), 0);
        check_val("busy_compute", int'(bus.busy), 1);
        wait_output(0, lat);
        check_val("c_latency", lat + 1, 16);
        check_val("busy_after_out", int'(bus.busy), 0);

        // Two-tile sweep
        send_tile(fill(1), fill(1), 1'b1, 1'b0, 1'b1);
        seen = 1'b0;
        repeat (17) begin
            @(negedge clock);
            seen |= bus.C_stb;
        end
        check_val("no_c_mid_sweep", int'(seen), 0);
        send_tile(fill(2), fill(3), 1'b0, 1'b1, 1'b1);
        wait_output(0, lat);

        // Wraparound
        send_tile(fill(32'h8000_0000), fill(2), 1'b1, 1'b1, 1'b1);
        wait_output(0, lat);
        send_tile(fill(32'hFFFF_FFFF), identity(), 1'b1, 1'b1, 1'b1);
        wait_output(2, lat);

        // Backpressure with upstream holding the next tile
        ta = rand_tile(); tb_t = rand_tile();
        send_tile(ta, tb_t, 1'b1, 1'b1, 1'b1);
        wait_c_stb(lat);
        na = rand_tile(); nb = rand_tile();
        drive_tile(na, nb, 1'b1, 1'b1);
        repeat (10) begin
            @(negedge clock);
            check_val("bp_no_ack", int'({bus.A_ack, bus.B_ack}), 0);
            check_val("bp_c_stb_held", int'(bus.C_stb), 1);
        end
        bus.C_ack = 1'b1;
        @(negedge clock);
        bus.C_ack = 1'b0;
        check_val("bp_c_stb_fall", int'(bus.C_stb), 0);
        check_val("bp_no_ack_yet", int'(bus.A_ack), 0);
        @(negedge clock);
        check_val("bp_accept_next", int'({bus.A_ack, bus.B_ack}), 3);
        if (bus.A_ack) model_issue(na, nb, 1'b1, 1'b1);
        drop_stb();
        wait_output(0, lat);

        // Partial strobe
        @(negedge clock);
        bus.A_in = rand_tile();
        bus.A_stb = 1'b1;
        bus.B_stb = 1'b0;
        repeat (5) begin
            @(negedge clock);
            check_val("partial_no_ack", int'({bus.A_ack, bus.B_ack}), 0);
            check_val("partial_idle", int'(bus.busy), 0);
        end
        drop_stb();

        // Strobes raised mid-compute are ignored until idle
        ta = rand_tile(); tb_t = rand_tile();
        send_tile(ta, tb_t, 1'b1, 1'b1, 1'b1);
        repeat (3) @(negedge clock);
        na = rand_tile(); nb = rand_tile();
        drive_tile(na, nb, 1'b1, 1'b1);
        seen = 1'b0;
        lat = 0;
        while (!bus.C_stb && lat < 40) begin
            @(negedge clock);
            lat++;
            seen |= (bus.A_ack | bus.B_ack);
        end
        check_val("busy_stb_ignored", int'(seen), 0);
        bus.C_ack = 1'b1;
        @(negedge clock);
        bus.C_ack = 1'b0;
        check_val("c_stb_one_cycle", int'(bus.C_stb), 0);
        wait_ack(ok);
        check_val("held_tile_accepted", int'(ok), 1);
        if (ok) model_issue(na, nb, 1'b1, 1'b1);
        drop_stb();
        wait_output(1, lat);

        // Reset mid-compute discards the partial tile
        send_tile(rand_tile(), rand_tile(), 1'b1, 1'b1, 1'b0);
        repeat (7) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        check_val("mid_rst_busy", int'(bus.busy), 0);
        check_val("mid_rst_acks", int'({bus.A_ack, bus.B_ack}), 0);
        check_val("mid_rst_c_stb", int'(bus.C_stb), 0);
        check_tile("mid_rst_c_out", bus.C_out, '0);
        reset = 1'b0;
        send_tile(rand_tile(), rand_tile(), 1'b1, 1'b1, 1'b1);
        wait_output(0, lat);

        // Random sweeps
        for (int s = 0; s < 8; s++) begin
            len = $urandom_range(1, 3);
            for (int t = 0; t < len; t++) begin
                send_tile(rand_tile(), rand_tile(), t == 0, t == len - 1, 1'b1);
                repeat ($urandom_range(0, 2)) @(negedge clock);
            end
            wait_output($urandom_range(0, 4), lat);
        end

        repeat (3) @(negedge clock);
        check_val("scoreboard_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d", checks, failures);
        $fatal(1);
    end
endmodule
